huffman_lut_scheduler: RTL and testbench

- Sequences the shared 64-entry codeword LUT (memory_unit) and the coder.
- Arbitrates between a table-load requester (LUT writes) and a symbol stream (LUT reads).
- Pipelines symbol lookups at 1 symbol/cycle and issues a coder enable only for non-zero-length codewords.
- Sits between the Avalon-side register logic and the memory_unit/coder pair.

---
 rtl/huffman_lut_scheduler.sv | 133 +++++++++++++
 tb/tb_huffman_lut_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_lut_scheduler.sv
// Schedules the shared codeword LUT between table writes and a 3-stage symbol lookup
// pipeline, and drives the coder only for codewords with a non-zero length.
module huffman_lut_scheduler #(
    parameter int ADDR_W = 6,
    parameter int CW_W   = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tbl_wr_req,
    input  logic [ADDR_W-1:0] tbl_wr_addr,
    input  logic [CW_W-1:0]   tbl_wr_data,
    output logic              tbl_wr_ack,
    input  logic              sym_valid,
    input  logic [ADDR_W-1:0] sym,
    output logic              sym_ready,
    output logic              lut_mode,
    output logic [ADDR_W-1:0] lut_addr,
    output logic [CW_W-1:0]   lut_data,
    input  logic [CW_W-1:0]   lut_codeword,
    output logic              coder_ce,
    output logic [7:0]        coder_code,
    output logic [3:0]        coder_length,
    output logic [CNT_W-1:0]  sym_count,
    output logic [CNT_W-1:0]  zero_len_count,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              s1_q, s1_d;
    logic              s2_q, s2_d;
    logic              s3_q, s3_d;
    logic              wr_ack_q, wr_ack_d;
    logic              sym_turn_q, sym_turn_d;
    logic [CW_W-1:0]   cw_q, cw_d;
    logic              lut_mode_q, lut_mode_d;
    logic [ADDR_W-1:0] lut_addr_q, lut_addr_d;
    logic [CW_W-1:0]   lut_data_q, lut_data_d;
    logic [CNT_W-1:0]  sym_cnt_q, sym_cnt_d;
    logic [CNT_W-1:0]  zlc_q, zlc_d;

    logic accept;
    logic grant;
    logic zero_len;

    // A pending write blocks symbols unless the symbol side holds the turn.
    assign sym_ready = !(tbl_wr_req && !sym_turn_q);
    assign accept    = sym_valid && sym_ready;
    assign grant     = tbl_wr_req && !wr_ack_q && !s1_q && !s2_q && !accept
                       && !(sym_turn_q && sym_valid);
    assign zero_len  = s3_q && (cw_q[3:0] == 4'd0);

    always_comb begin
        s1_d       = accept;
        s2_d       = s1_q;
        s3_d       = s2_q;
        wr_ack_d   = grant;
        cw_d       = cw_q;
        lut_mode_d = 1'b0;
        lut_addr_d = lut_addr_q;
        lut_data_d = lut_data_q;
        sym_turn_d = sym_turn_q;
        sym_cnt_d  = sym_cnt_q;
        zlc_d      = zlc_q;

        if (s2_q) begin
            cw_d = lut_codeword;
        end

        if (accept) begin
            lut_addr_d = sym;
        end else if (grant) begin
            lut_mode_d = 1'b1;
            lut_addr_d = tbl_wr_addr;
            lut_data_d = tbl_wr_data;
        end

        // Setting the turn on grant wins over clearing in the same cycle.
        if (grant) begin
            sym_turn_d = 1'b1;
        end else if (!wr_ack_q && (accept || !sym_valid)) begin
            sym_turn_d = 1'b0;
        end

        if (s3_q) begin
            sym_cnt_d = sym_cnt_q + CNT_ONE;
        end
        if (zero_len && (zlc_q != {CNT_W{1'b1}})) begin
            zlc_d = zlc_q + CNT_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            wr_ack_q   <= 1'b0;
            sym_turn_q <= 1'b0;
            cw_q       <= '0;
            lut_mode_q <= 1'b0;
            lut_addr_q <= '0;
            lut_data_q <= '0;
            sym_cnt_q  <= '0;
            zlc_q      <= '0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            wr_ack_q   <= wr_ack_d;
            sym_turn_q <= sym_turn_d;
            cw_q       <= cw_d;
            lut_mode_q <= lut_mode_d;
            lut_addr_q <= lut_addr_d;
            lut_data_q <= lut_data_d;
            sym_cnt_q  <= sym_cnt_d;
            zlc_q      <= zlc_d;
        end
    end

    assign tbl_wr_ack     = wr_ack_q;
    assign lut_mode       = lut_mode_q;
    assign lut_addr       = lut_addr_q;
    assign lut_data       = lut_data_q;
    assign coder_ce       = s3_q && (cw_q[3:0] != 4'd0);
    assign coder_code     = cw_q[CW_W-1:4];
    assign coder_length   = cw_q[3:0];
    assign sym_count      = sym_cnt_q;
    assign zero_len_count = zlc_q;
    assign busy           = s1_q || s2_q || s3_q || wr_ack_q || grant;

endmodule

// File: tb/tb_huffman_lut_scheduler.sv
// Directed bench for huffman_lut_scheduler with a registered LUT model and a coder
// output scoreboard; every expected value below is worked out by hand cycle by cycle.
module tb_huffman_lut_scheduler;

    localparam int ADDR_W = 6;
    localparam int CW_W   = 12;
    localparam int CNT_W  = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic              tbl_wr_req;
    logic [ADDR_W-1:0] tbl_wr_addr;
    logic [CW_W-1:0]   tbl_wr_data;
    logic              tbl_wr_ack;
    logic              sym_valid;
    logic [ADDR_W-1:0] sym;
    logic              sym_ready;
    logic              lut_mode;
    logic [ADDR_W-1:0] lut_addr;
    logic [CW_W-1:0]   lut_data;
    logic [CW_W-1:0]   lut_codeword;
    logic              coder_ce;
    logic [7:0]        coder_code;
    logic [3:0]        coder_length;
    logic [CNT_W-1:0]  sym_count;
    logic [CNT_W-1:0]  zero_len_count;
    logic              busy;

    int errors = 0;
    int checks = 0;
    logic [CW_W-1:0] exp_q[$];
    logic [CW_W-1:0] lut_mem [64];

    huffman_lut_scheduler #(.ADDR_W(ADDR_W), .CW_W(CW_W), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .tbl_wr_req(tbl_wr_req), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
        .tbl_wr_ack(tbl_wr_ack),
        .sym_valid(sym_valid), .sym(sym), .sym_ready(sym_ready),
        .lut_mode(lut_mode), .lut_addr(lut_addr), .lut_data(lut_data),
        .lut_codeword(lut_codeword),
        .coder_ce(coder_ce), .coder_code(coder_code), .coder_length(coder_length),
        .sym_count(sym_count), .zero_len_count(zero_len_count), .busy(busy)
    );

    // clock / reset
    always #5 clock = ~clock;

    // registered memory_unit model
    always @(posedge clock) begin
        if (lut_mode) lut_mem[lut_addr] <= lut_data;
        lut_codeword <= lut_mem[lut_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // scoreboard: each coder enable must match the oldest expected codeword
    always @(negedge clock) begin
        if (coder_ce === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("ce_unexpected", {31'd0, coder_ce}, 32'd0);
            end else begin
                logic [CW_W-1:0] e;
                e = exp_q.pop_front();
                chk("coder_code", {24'd0, coder_code}, {24'd0, e[11:4]});
                chk("coder_length", {28'd0, coder_length}, {28'd0, e[3:0]});
            end
        end
    end

    initial begin
        reset = 1'b1; tbl_wr_req = 1'b0; tbl_wr_addr = '0; tbl_wr_data = '0;
        sym_valid = 1'b0; sym = '0;
        tick(); tick();
        chk("rst_ack", {31'd0, tbl_wr_ack}, 0);
        chk("rst_mode", {31'd0, lut_mode}, 0);
        chk("rst_addr", {26'd0, lut_addr}, 0);
        chk("rst_data", {20'd0, lut_data}, 0);
        chk("rst_ce", {31'd0, coder_ce}, 0);
        chk("rst_cnt", {16'd0, sym_count}, 0);
        chk("rst_zlc", {16'd0, zero_len_count}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_ready", {31'd0, sym_ready}, 1);
        reset = 1'b0;
        tick();

        // table writes, request held: grant, ack, grant, ack ...
        tbl_wr_req = 1'b1; tbl_wr_addr = 6'd5; tbl_wr_data = 12'hA53;
        #1 chk("w1_ready_low", {31'd0, sym_ready}, 0);
        chk("w1_no_ack_yet", {31'd0, tbl_wr_ack}, 0);
        tick();
        chk("w1_ack", {31'd0, tbl_wr_ack}, 1);
        chk("w1_mode", {31'd0, lut_mode}, 1);
        chk("w1_addr", {26'd0, lut_addr}, 5);
        chk("w1_data", {20'd0, lut_data}, 32'hA53);
        tbl_wr_addr = 6'd6; tbl_wr_data = 12'h000;
        tick();
        chk("w2_gap_ack", {31'd0, tbl_wr_ack}, 0);
        chk("w2_gap_mode", {31'd0, lut_mode}, 0);
        tick();
        chk("w2_ack", {31'd0, tbl_wr_ack}, 1);
        chk("w2_addr", {26'd0, lut_addr}, 6);
        chk("w2_data", {20'd0, lut_data}, 0);
        tbl_wr_addr = 6'd7; tbl_wr_data = 12'hFF8;
        tick();
        chk("w3_gap_ack", {31'd0, tbl_wr_ack}, 0);
        tick();
        chk("w3_ack", {31'd0, tbl_wr_ack}, 1);
        chk("w3_mode", {31'd0, lut_mode}, 1);
        chk("w3_addr", {26'd0, lut_addr}, 7);
        chk("w3_data", {20'd0, lut_data}, 32'hFF8);
        tbl_wr_req = 1'b0;
        tick();
        chk("w_idle_busy", {31'd0, busy}, 0);

        // symbols 5, 7, 5 back to back
        sym_valid = 1'b1; sym = 6'd5; exp_q.push_back(12'hA53);
        #1 chk("s_ready", {31'd0, sym_ready}, 1);
        tick();
        chk("s_t1_mode", {31'd0, lut_mode}, 0);
        chk("s_t1_addr", {26'd0, lut_addr}, 5);
        chk("s_t1_ce", {31'd0, coder_ce}, 0);
        sym = 6'd7; exp_q.push_back(12'hFF8);
        tick();
        chk("s_t2_addr", {26'd0, lut_addr}, 7);
        chk("s_t2_ce", {31'd0, coder_ce}, 0);
        sym = 6'd5; exp_q.push_back(12'hA53);
        tick();
        sym_valid = 1'b0;
        chk("s_t3_ce", {31'd0, coder_ce}, 1);
        chk("s_t3_addr", {26'd0, lut_addr}, 5);
        tick();
        chk("s_t4_ce", {31'd0, coder_ce}, 1);
        tick();
        chk("s_t5_ce", {31'd0, coder_ce}, 1);
        chk("s_t5_cnt", {16'd0, sym_count}, 2);
        tick();
        chk("s_t6_ce", {31'd0, coder_ce}, 0);
        chk("s_t6_cnt", {16'd0, sym_count}, 3);
        chk("s_t6_busy", {31'd0, busy}, 0);

        // zero-length codeword
        sym_valid = 1'b1; sym = 6'd6;
        tick();
        sym_valid = 1'b0;
        tick(); tick();
        chk("z_t3_ce", {31'd0, coder_ce}, 0);
        chk("z_t3_zlc", {16'd0, zero_len_count}, 0);
        tick();
        chk("z_t4_zlc", {16'd0, zero_len_count}, 1);
        chk("z_t4_cnt", {16'd0, sym_count}, 4);

        // write arrives with two symbols in flight and a third held valid
        sym_valid = 1'b1; sym = 6'd5; exp_q.push_back(12'hA53);
        tick();
        sym = 6'd7; exp_q.push_back(12'hFF8);
        tick();
        sym = 6'd5;
        tbl_wr_req = 1'b1; tbl_wr_addr = 6'd10; tbl_wr_data = 12'h123;
        #1 chk("f_a2_ready", {31'd0, sym_ready}, 0);
        tick();
        chk("f_a3_ready", {31'd0, sym_ready}, 0);
        chk("f_a3_ack", {31'd0, tbl_wr_ack}, 0);
        tick();
        chk("f_a4_ack", {31'd0, tbl_wr_ack}, 0);
        chk("f_a4_busy", {31'd0, busy}, 1);
        tick();
        chk("f_a5_ack", {31'd0, tbl_wr_ack}, 1);
        chk("f_a5_mode", {31'd0, lut_mode}, 1);
        chk("f_a5_addr", {26'd0, lut_addr}, 10);
        chk("f_a5_data", {20'd0, lut_data}, 32'h123);
        tbl_wr_addr = 6'd11; tbl_wr_data = 12'h456;
        #1 chk("f_a5_ready", {31'd0, sym_ready}, 1);
        exp_q.push_back(12'hA53);
        tick();
        chk("f_a6_mode", {31'd0, lut_mode}, 0);
        chk("f_a6_addr", {26'd0, lut_addr}, 5);
        chk("f_a6_ack", {31'd0, tbl_wr_ack}, 0);
        sym_valid = 1'b0;
        tick();
        chk("f_a7_ready", {31'd0, sym_ready}, 0);
        chk("f_a7_ack", {31'd0, tbl_wr_ack}, 0);
        tick();
        chk("f_a8_ack", {31'd0, tbl_wr_ack}, 0);
        tick();
        chk("f_a9_ack", {31'd0, tbl_wr_ack}, 1);
        chk("f_a9_addr", {26'd0, lut_addr}, 11);
        chk("f_a9_data", {20'd0, lut_data}, 32'h456);
        tbl_wr_req = 1'b0;
        tick();

        // reset in the cycle after a symbol is accepted, with a write pending
        sym_valid = 1'b1; sym = 6'd5;
        tick();
        sym_valid = 1'b0; reset = 1'b1;
        tbl_wr_req = 1'b1; tbl_wr_addr = 6'd12; tbl_wr_data = 12'h777;
        tick();
        reset = 1'b0; tbl_wr_req = 1'b0;
        #1 chk("r_ack", {31'd0, tbl_wr_ack}, 0);
        chk("r_mode", {31'd0, lut_mode}, 0);
        chk("r_addr", {26'd0, lut_addr}, 0);
        chk("r_data", {20'd0, lut_data}, 0);
        chk("r_ce", {31'd0, coder_ce}, 0);
        chk("r_code", {24'd0, coder_code}, 0);
        chk("r_len", {28'd0, coder_length}, 0);
        chk("r_cnt", {16'd0, sym_count}, 0);
        chk("r_zlc", {16'd0, zero_len_count}, 0);
        chk("r_busy", {31'd0, busy}, 0);
        tick();
        chk("r_t3_ce", {31'd0, coder_ce}, 0);
        chk("r_t3_ack", {31'd0, tbl_wr_ack}, 0);
        tick();
        chk("r_t4_ce", {31'd0, coder_ce}, 0);
        chk("r_t4_ack", {31'd0, tbl_wr_ack}, 0);

        // 65536 zero-length symbols: sym_count wraps, zero_len_count saturates
        sym_valid = 1'b1; sym = 6'd6;
        for (int i = 0; i < 65535; i++) tick();
        tick();
        sym_valid = 1'b0;
        tick(); tick();
        chk("wrap_l3_busy", {31'd0, busy}, 1);
        chk("wrap_l3_cnt", {16'd0, sym_count}, 32'hFFFF);
        chk("wrap_l3_ce", {31'd0, coder_ce}, 0);
        tick();
        chk("wrap_l4_busy", {31'd0, busy}, 0);
        chk("wrap_l4_cnt", {16'd0, sym_count}, 0);
        chk("wrap_l4_zlc", {16'd0, zero_len_count}, 32'hFFFF);
        sym_valid = 1'b1; sym = 6'd6;
        tick();
        sym_valid = 1'b0;
        tick(); tick(); tick();
        chk("sat_cnt", {16'd0, sym_count}, 1);
        chk("sat_zlc", {16'd0, zero_len_count}, 32'hFFFF);

        chk("exp_q_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
